// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch path: the buffered fetch entry,
// the fetch state encoding and the default terminator word.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] END_INSN_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO holding fetched {pc, instr} entries.
// Flush empties it in one edge and takes priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int DW         = $bits(fetch_entry_t),
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [DW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A push into a full FIFO is only accepted when the head leaves the same cycle.
        push_ok  = push && (!full || pop);
        pop_ok   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: owns the PC, issues credit-limited reads to a
// 1-cycle-latency memory and hands {pc, instr} to decode over valid/ready.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned PROG_BYTES = 1024,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] END_INSN   = END_INSN_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_complete
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] PROG_END = 32'(PROG_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tag_q, tag_d;
    logic         inflight_q, inflight_d;
    logic         drop_q, drop_d;
    logic         fetch_complete_q, fetch_complete_d;

    logic          issue;
    logic          redirect_take;
    logic          resp_live;
    logic          end_seen;
    logic          fifo_push, fifo_pop, fifo_flush;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_req       = issue;
    assign imem_addr      = pc_q;
    assign out_valid      = !fifo_empty;
    assign out_pc         = head_entry.pc;
    assign out_instr      = head_entry.instr;
    assign fetch_complete = fetch_complete_q;

    always_comb begin
        // Credits count what was held at the start of the cycle; a pop now frees nothing until next cycle.
        issue = (state_q == RUN) && !reset && !redirect_valid && (pc_q < PROG_END) &&
                !fifo_full && ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);
        redirect_take = redirect_valid && (state_q != DONE);
        resp_live     = inflight_q && !drop_q && !redirect_take;
        end_seen      = resp_live && (imem_rdata == END_INSN);
        fifo_push     = resp_live && !end_seen;
        fifo_pop      = !fifo_empty && out_ready;
        fifo_flush    = redirect_take;
        push_entry    = '{pc: tag_q, instr: imem_rdata};

        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        drop_d     = 1'b0;
        state_d    = state_q;

        if (issue) begin
            pc_d  = pc_q + 32'd4;
            tag_d = pc_q;
        end

        case (state_q)
            RUN: begin
                if (end_seen) begin
                    state_d = DRAIN;
                end else if ((pc_q >= PROG_END) && !inflight_q) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = state_q;
        endcase

        // A word requested alongside the terminator lies past the program end.
        if (end_seen && issue) begin
            drop_d = 1'b1;
        end

        if (redirect_take) begin
            pc_d    = align_word(redirect_pc);
            state_d = RUN;
        end

        count_next = redirect_take ? '0 : (fifo_count + CW'(fifo_push) - CW'(fifo_pop));
        if ((state_d == DRAIN) && (count_next == '0) && !inflight_d) begin
            state_d = DONE;
        end

        fetch_complete_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            pc_q             <= RESET_PC;
            tag_q            <= '0;
            inflight_q       <= 1'b0;
            drop_q           <= 1'b0;
            fetch_complete_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            tag_q            <= tag_d;
            inflight_q       <= inflight_d;
            drop_q           <= drop_d;
            fetch_complete_q <= fetch_complete_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a default-parameter instance and a
// PROG_BYTES=16 instance, each fed by a 1-cycle-latency memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] W0  = 32'h0050_0093;
    localparam logic [31:0] W1  = 32'h00A0_0113;
    localparam logic [31:0] W2  = 32'h0020_81B3;
    localparam logic [31:0] W40 = 32'h0010_0513;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        imem_req, imem_req_b;
    logic [31:0] imem_addr, imem_addr_b;
    logic [31:0] imem_rdata = 32'h0, imem_rdata_b = 32'h0;
    logic        redirect_valid = 1'b0, redirect_valid_b = 1'b0;
    logic [31:0] redirect_pc = 32'h0, redirect_pc_b = 32'h0;
    logic        out_valid, out_valid_b;
    logic        out_ready = 1'b0, out_ready_b = 1'b0;
    logic [31:0] out_pc, out_pc_b, out_instr, out_instr_b;
    logic        fetch_complete, fetch_complete_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic        req_a_s = 1'b0, req_b_s = 1'b0;
    logic [31:0] addr_a_s = 32'h0, addr_b_s = 32'h0;

    instr_fetch_unit #(.RESET_PC(32'h0), .PROG_BYTES(1024), .FIFO_DEPTH(2), .END_INSN(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .fetch_complete(fetch_complete)
    );

    instr_fetch_unit #(.RESET_PC(32'h0), .PROG_BYTES(16), .FIFO_DEPTH(2), .END_INSN(32'h0)) dut_b (
        .clk(clk), .reset(reset), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_rdata(imem_rdata_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b), .out_instr(out_instr_b),
        .fetch_complete(fetch_complete_b)
    );

    // Memory models: capture the request mid-cycle, present data for the next cycle.
    always @(negedge clk) begin
        req_a_s  <= imem_req;
        addr_a_s <= imem_addr;
        req_b_s  <= imem_req_b;
        addr_b_s <= imem_addr_b;
    end

    always @(posedge clk) begin
        #1;
        imem_rdata   = req_a_s ? mem_a[addr_a_s[9:2]] : 32'hDEAD_BEEF;
        imem_rdata_b = req_b_s ? mem_b[addr_b_s[9:2]] : 32'hDEAD_BEEF;
    end

    task automatic init_mems();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0A00_0000 + i;
            mem_b[i] = 32'h0B00_0000 + i;
        end
        mem_a[0]  = W0;
        mem_a[1]  = W1;
        mem_a[2]  = W2;
        mem_a[3]  = 32'h0000_0000;
        mem_a[16] = W40;
    endtask

    // Returns at the start of cycle 0, the first cycle with reset low.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        out_ready_b    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || fetch_complete !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b req=%b done=%b, want 0 0 0", out_valid, imem_req, fetch_complete);
        end
        checks++;
        if (imem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h pc=%h instr=%h, want all 0", imem_addr, out_pc, out_instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_program();
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_in [3] = '{W0, W1, W2};
        logic [31:0] hs_pc [$];
        logic [31:0] hs_in [$];
        int          hs_cyc [$];
        logic        fc [12];
        int          last;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            fc[c] = fetch_complete;
            if (c < 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid: cycle %0d out_valid=%b, want 0", c, out_valid);
                end
            end
            if (c == 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== W0) begin
                    errors++;
                    $display("FAIL basic_first: valid=%b pc=%h instr=%h, want 1 0 %h", out_valid, out_pc, out_instr, W0);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                hs_pc.push_back(out_pc);
                hs_in.push_back(out_instr);
                hs_cyc.push_back(c);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hs_pc.size() != 3) begin
            errors++;
            $display("FAIL basic_count: %0d deliveries, want 3", hs_pc.size());
        end
        for (int i = 0; i < 3 && i < hs_pc.size(); i++) begin
            checks++;
            if (hs_pc[i] !== exp_pc[i] || hs_in[i] !== exp_in[i]) begin
                errors++;
                $display("FAIL basic_seq[%0d]: pc=%h instr=%h, want %h %h", i, hs_pc[i], hs_in[i], exp_pc[i], exp_in[i]);
            end
        end
        if (hs_cyc.size() > 0) begin
            last = hs_cyc[hs_cyc.size() - 1];
            if (last < 11) begin
                checks++;
                if (fc[last] !== 1'b0 || fc[last + 1] !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_done_edge: done at last hs=%b after=%b, want 0 1", fc[last], fc[last + 1]);
                end
            end
        end
        checks++;
        if (fc[11] !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_hold: done=%b req=%b, want 1 0", fc[11], imem_req);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] hs_pc [$];
        int          stall_req = 0;
        int          unstable  = 0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            out_ready = (c >= 11);
            @(negedge clk);
            if (c == 0 || c == 1) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(c * 4)) begin
                    errors++;
                    $display("FAIL stall_issue: cycle %0d req=%b addr=%h, want 1 %h", c, imem_req, imem_addr, 32'(c * 4));
                end
            end
            if (c >= 2 && c <= 10 && imem_req !== 1'b0) stall_req++;
            if (c >= 2 && c <= 10 && (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== W0)) unstable++;
            if (out_valid === 1'b1 && out_ready === 1'b1) hs_pc.push_back(out_pc);
            @(posedge clk);
            #1;
        end
        checks++;
        if (stall_req != 0) begin
            errors++;
            $display("FAIL stall_credit: %0d request cycles while 2 held, want 0", stall_req);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL stall_stable: %0d unstable cycles, want 0", unstable);
        end
        checks++;
        if (hs_pc.size() != 3) begin
            errors++;
            $display("FAIL stall_count: %0d deliveries, want 3", hs_pc.size());
        end
        for (int i = 0; i < 3 && i < hs_pc.size(); i++) begin
            checks++;
            if (hs_pc[i] !== exp_pc[i]) begin
                errors++;
                $display("FAIL stall_seq[%0d]: pc=%h, want %h", i, hs_pc[i], exp_pc[i]);
            end
        end
        checks++;
        if (fetch_complete !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: fetch_complete=%b, want 1", fetch_complete);
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] hs_pc [$];
        logic [31:0] hs_in [$];
        do_reset();
        for (int c = 0; c < 15; c++) begin
            redirect_valid = (c == 2);
            redirect_pc    = 32'h40;
            out_ready      = (c >= 3);
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_cycle: valid=%b pc=%h req=%b, want 1 0 0", out_valid, out_pc, imem_req);
                end
            end
            if (c == 3) begin
                checks++;
                if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL redir_flush: valid=%b req=%b addr=%h, want 0 1 40", out_valid, imem_req, imem_addr);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                hs_pc.push_back(out_pc);
                hs_in.push_back(out_instr);
            end
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        checks++;
        if (hs_pc.size() < 2) begin
            errors++;
            $display("FAIL redir_count: %0d deliveries, want at least 2", hs_pc.size());
        end else begin
            checks++;
            if (hs_pc[0] !== 32'h40 || hs_in[0] !== W40) begin
                errors++;
                $display("FAIL redir_first: pc=%h instr=%h, want 40 %h", hs_pc[0], hs_in[0], W40);
            end
            checks++;
            if (hs_pc[1] !== 32'h44 || hs_in[1] !== 32'h0A00_0011) begin
                errors++;
                $display("FAIL redir_second: pc=%h instr=%h, want 44 0a000011", hs_pc[1], hs_in[1]);
            end
        end
        for (int i = 0; i < hs_pc.size(); i++) begin
            checks++;
            if (hs_pc[i] < 32'h40) begin
                errors++;
                $display("FAIL redir_stale[%0d]: pc=%h, want >= 40", i, hs_pc[i]);
            end
        end
    endtask

    task automatic test_redirect_end();
        logic [31:0] hs_pc [$];
        int          done_seen = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            redirect_valid = (c == 5);
            redirect_pc    = 32'h40;
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
                    errors++;
                    $display("FAIL rend_req_c: req=%b addr=%h, want 1 c", imem_req, imem_addr);
                end
            end
            if (fetch_complete === 1'b1) done_seen++;
            if (out_valid === 1'b1 && out_ready === 1'b1) hs_pc.push_back(out_pc);
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rend_no_done: fetch_complete high %0d cycles, want 0", done_seen);
        end
        checks++;
        if (hs_pc.size() < 4) begin
            errors++;
            $display("FAIL rend_count: %0d deliveries, want at least 4", hs_pc.size());
        end else if (hs_pc[2] !== 32'h8 || hs_pc[3] !== 32'h40) begin
            errors++;
            $display("FAIL rend_seq: pcs %h %h, want 8 40", hs_pc[2], hs_pc[3]);
        end
    endtask

    task automatic test_redirect_handshake();
        logic [31:0] hs_pc [$];
        logic [31:0] hs_in [$];
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            redirect_valid = (c == 3);
            redirect_pc    = 32'h22;
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rhs_cycle: valid=%b pc=%h req=%b, want 1 4 0", out_valid, out_pc, imem_req);
                end
            end
            if (c == 4) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
                    errors++;
                    $display("FAIL rhs_align: req=%b addr=%h, want 1 20", imem_req, imem_addr);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                hs_pc.push_back(out_pc);
                hs_in.push_back(out_instr);
            end
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        checks++;
        if (hs_pc.size() < 3) begin
            errors++;
            $display("FAIL rhs_count: %0d deliveries, want at least 3", hs_pc.size());
        end else if (hs_pc[1] !== 32'h4 || hs_pc[2] !== 32'h20 || hs_in[2] !== 32'h0A00_0008) begin
            errors++;
            $display("FAIL rhs_seq: pcs %h %h instr %h, want 4 20 0a000008", hs_pc[1], hs_pc[2], hs_in[2]);
        end
    endtask

    task automatic test_prog_bound();
        logic [31:0] hs_pc [$];
        logic [31:0] hs_in [$];
        int          hs_cyc [$];
        logic        fc [15];
        int          bad_addr = 0;
        int          last;
        do_reset();
        out_ready_b = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            fc[c] = fetch_complete_b;
            if (imem_req_b === 1'b1 && imem_addr_b >= 32'h10) bad_addr++;
            if (out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
                hs_pc.push_back(out_pc_b);
                hs_in.push_back(out_instr_b);
                hs_cyc.push_back(c);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL bound_addr: %0d requests at or past 0x10, want 0", bad_addr);
        end
        checks++;
        if (hs_pc.size() != 4) begin
            errors++;
            $display("FAIL bound_count: %0d deliveries, want 4", hs_pc.size());
        end
        for (int i = 0; i < 4 && i < hs_pc.size(); i++) begin
            checks++;
            if (hs_pc[i] !== 32'(i * 4) || hs_in[i] !== 32'h0B00_0000 + 32'(i)) begin
                errors++;
                $display("FAIL bound_seq[%0d]: pc=%h instr=%h, want %h %h", i, hs_pc[i], hs_in[i], 32'(i * 4), 32'h0B00_0000 + 32'(i));
            end
        end
        if (hs_cyc.size() > 0) begin
            last = hs_cyc[hs_cyc.size() - 1];
            if (last < 14) begin
                checks++;
                if (fc[last] !== 1'b0 || fc[last + 1] !== 1'b1) begin
                    errors++;
                    $display("FAIL bound_done_edge: done at last hs=%b after=%b, want 0 1", fc[last], fc[last + 1]);
                end
            end
        end
        checks++;
        if (fc[14] !== 1'b1) begin
            errors++;
            $display("FAIL bound_done_hold: fetch_complete=%b, want 1", fc[14]);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            reset     = (c == 4 || c == 5);
            out_ready = (c >= 8);
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (out_valid !== 1'b1 || imem_req !== 1'b0 || out_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_full: valid=%b req=%b pc=%h, want 1 0 0", out_valid, imem_req, out_pc);
                end
            end
            if (c == 5) begin
                checks++;
                if (out_valid !== 1'b0 || imem_req !== 1'b0 || fetch_complete !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_reset: valid=%b req=%b done=%b pc=%h instr=%h, want 0 0 0 0 0",
                             out_valid, imem_req, fetch_complete, out_pc, out_instr);
                end
            end
            if (c == 6) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_restart: req=%b addr=%h, want 1 0", imem_req, imem_addr);
                end
            end
            if (c == 8) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== W0) begin
                    errors++;
                    $display("FAIL mid_first: valid=%b pc=%h instr=%h, want 1 0 %h", out_valid, out_pc, out_instr, W0);
                end
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        init_mems();
        @(posedge clk);
        #1;
        test_reset();
        test_basic_program();
        test_stall();
        test_redirect_inflight();
        test_redirect_end();
        test_redirect_handshake();
        test_prog_bound();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
